// File: rtl/cordic_cos_sequencer_if.sv
// Custom-instruction and CORDIC-core signal bundle for the cosine sequencer.
// master = CPU/core environment side, slave = sequencer side.
interface cordic_cos_sequencer_if #(
  parameter int WL     = 21,
  parameter int ITER_W = 5
);
  logic              clk_en;
  logic              start;
  logic [31:0]       dataa;
  logic              done;
  logic [31:0]       result;
  logic              core_load;
  logic [WL-1:0]     core_angle;
  logic              core_step;
  logic [ITER_W-1:0] core_iter;
  logic [WL-1:0]     core_cos;

  modport master (
    output clk_en, start, dataa, core_cos,
    input  done, result, core_load, core_angle, core_step, core_iter
  );

  modport slave (
    input  clk_en, start, dataa, core_cos,
    output done, result, core_load, core_angle, core_step, core_iter
  );
endinterface

// File: rtl/cordic_cos_sequencer.sv
// Cosine CORDIC front end: float angle -> 1.20 fixed, N_ITER core steps, cosine -> float.
// Latency N_ITER+3 enabled cycles; start ignored while busy. Optional CORDIC_SEQ_PERF_EN adds perf_ops.

// Float magnitude to unsigned 1.(WL-1) fixed, truncating; |x|>=2.0 saturates.
module cordic_f2x #(
  parameter int WL = 21
) (
  input  logic [31:0]   f,
  output logic [WL-1:0] x
);
  logic [7:0]  exp_f;
  logic [23:0] mant;
  logic [8:0]  sh;

  always_comb begin
    exp_f = f[30:23];
    mant  = {1'b1, f[22:0]};
    sh    = 9'd150 - 9'(WL - 1) - {1'b0, exp_f};
    x     = '0;
    if (exp_f == 8'd0) begin
      x = '0;
    end else if (exp_f > 8'd127) begin
      x = '1;
    end else if (sh >= 9'd24) begin
      x = '0;
    end else begin
      x = WL'(mant >> sh);
    end
  end
endmodule

// Unsigned 1.(WL-1) fixed to positive float; exact because WL <= 24.
module cordic_x2f #(
  parameter int WL = 21
) (
  input  logic [WL-1:0] x,
  output logic [31:0]   f
);
  int          p;
  logic [22:0] xe;
  logic [22:0] mant;
  logic [7:0]  exp_f;

  always_comb begin
    p = 0;
    for (int i = 0; i < WL; i++) begin
      if (x[i]) p = i;
    end
    xe    = 23'(x);
    // Leading one shifts out past bit 22, leaving only the fraction bits.
    mant  = xe << (23 - p);
    exp_f = 8'(127 - (WL - 1) + p);
    f     = (x == '0) ? 32'h0000_0000 : {1'b0, exp_f, mant};
  end
endmodule

module cordic_cos_sequencer #(
  parameter int WL     = 21,
  parameter int N_ITER = 16,
  parameter int ITER_W = 5
) (
  input  logic                    clk,
  input  logic                    reset_n,
  cordic_cos_sequencer_if.slave   bus
`ifdef CORDIC_SEQ_PERF_EN
  ,
  output logic [15:0]             perf_ops
`endif
);
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_ITER = 3'd2,
    S_PACK = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(N_ITER - 1);

  state_t            state_q, state_d;
  logic [31:0]       in_reg_q, in_reg_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [31:0]       result_q, result_d;

  logic [WL-1:0]     angle_fx;
  logic [31:0]       cos_fp;
  logic [31:0]       packed_res;
  logic [7:0]        in_exp;

  // Sign bit dropped: cos is even.
  cordic_f2x #(.WL(WL)) u_f2x (
    .f (in_reg_q & 32'h7FFF_FFFF),
    .x (angle_fx)
  );

  cordic_x2f #(.WL(WL)) u_x2f (
    .x (bus.core_cos),
    .f (cos_fp)
  );

  always_comb begin
    in_exp = in_reg_q[30:23];
    // Exponent 0 covers both true zero and denormals, which are flushed to zero.
    if (in_exp > 8'd127) begin
      packed_res = 32'h7FC0_0000;
    end else if (in_exp == 8'd0) begin
      packed_res = 32'h3F80_0000;
    end else if (bus.core_cos == '0) begin
      packed_res = 32'h0000_0000;
    end else begin
      packed_res = cos_fp;
    end
  end

  always_comb begin
    state_d  = state_q;
    in_reg_d = in_reg_q;
    iter_d   = iter_q;
    result_d = result_q;
    if (bus.clk_en) begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            in_reg_d = bus.dataa;
            state_d  = S_LOAD;
          end
        end
        S_LOAD: begin
          iter_d  = '0;
          state_d = S_ITER;
        end
        S_ITER: begin
          iter_d = iter_q + 1'b1;
          if (iter_q == LAST_ITER) state_d = S_PACK;
        end
        S_PACK: begin
          result_d = packed_res;
          state_d  = S_DONE;
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      in_reg_q <= '0;
      iter_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      in_reg_q <= in_reg_d;
      iter_q   <= iter_d;
      result_q <= result_d;
    end
  end

  assign bus.core_load  = bus.clk_en && (state_q == S_LOAD);
  assign bus.core_step  = bus.clk_en && (state_q == S_ITER);
  assign bus.done       = bus.clk_en && (state_q == S_DONE);
  assign bus.core_angle = angle_fx;
  assign bus.core_iter  = iter_q;
  assign bus.result     = result_q;

`ifdef CORDIC_SEQ_PERF_EN
  logic [15:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (bus.clk_en && (state_q == S_DONE)) perf_d = perf_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_ops = perf_q;
`endif
endmodule

// File: tb/tb_cordic_cos_sequencer.sv
// Self-checking bench for cordic_cos_sequencer with a behavioural CORDIC core stand-in.
// Expected results are queued at stimulus time and compared when done pulses.
module tb_cordic_cos_sequencer;
  localparam int WL     = 21;
  localparam int ITER_W = 5;
  localparam int N_ITER = 16;

  logic clk;
  logic reset_n;
  cordic_cos_sequencer_if #(.WL(WL), .ITER_W(ITER_W)) bus ();
`ifdef CORDIC_SEQ_PERF_EN
  logic [15:0] perf_ops;
`endif

  cordic_cos_sequencer #(.WL(WL), .N_ITER(N_ITER), .ITER_W(ITER_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef CORDIC_SEQ_PERF_EN
    ,
    .perf_ops(perf_ops)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Stand-in core: arbitrary but deterministic recurrence; the tiny angle 1 lsb yields zero.
  function automatic logic [WL-1:0] core_next(logic [WL-1:0] x, logic [WL-1:0] z, int i);
    if (z == 21'd1) return '0;
    return WL'((x >> 1) + (z >> i) + i * 21'h00123);
  endfunction

  function automatic logic [WL-1:0] core_init(logic [WL-1:0] z);
    return (z == 21'd1) ? 21'd0 : 21'h09B74F;
  endfunction

  logic [WL-1:0] mc_x, mc_z;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mc_x <= '0;
      mc_z <= '0;
    end else if (bus.core_load) begin
      mc_x <= core_init(bus.core_angle);
      mc_z <= bus.core_angle;
    end else if (bus.core_step) begin
      mc_x <= core_next(mc_x, mc_z, int'(bus.core_iter));
    end
  end
  assign bus.core_cos = mc_x;

  function automatic logic [WL-1:0] model_f2x(logic [31:0] f);
    int     e;
    longint m;
    e = int'(f[30:23]);
    m = longint'({1'b1, f[22:0]});
    if (e == 0) return '0;
    if (e > 127) return '1;
    if (130 - e >= 40) return '0;
    return WL'(m / (longint'(1) << (130 - e)));
  endfunction

  function automatic logic [31:0] model_x2f(logic [WL-1:0] x);
    int          m;
    int          e;
    logic [22:0] frac;
    if (x == '0) return 32'h0;
    m = int'(x);
    e = 127;
    while (m < (1 << 20)) begin
      m = m << 1;
      e = e - 1;
    end
    frac = 23'((m - (1 << 20)) << 3);
    return {1'b0, 8'(e), frac};
  endfunction

  function automatic logic [31:0] model_result(logic [31:0] a);
    logic [WL-1:0] z, x;
    int            e;
    e = int'(a[30:23]);
    z = model_f2x({1'b0, a[30:0]});
    x = core_init(z);
    for (int i = 0; i < N_ITER; i++) x = core_next(x, z, i);
    if (e > 127) return 32'h7FC00000;
    if (e == 0) return 32'h3F800000;
    if (x == '0) return 32'h00000000;
    return model_x2f(x);
  endfunction

  typedef struct {
    logic [31:0]   res;
    logic [WL-1:0] angle;
  } exp_t;
  exp_t sb[$];

  // Passive monitor: tallies core/done activity; cleared on request.
  bit            clr = 0;
  int            load_cnt, step_cnt, iter_bad, done_cnt;
  logic [WL-1:0] load_angle;
  always @(negedge clk) begin
    if (clr) begin
      load_cnt = 0; step_cnt = 0; iter_bad = 0; done_cnt = 0; load_angle = '0;
    end else begin
      if (bus.core_load === 1'b1) begin
        load_cnt++;
        load_angle = bus.core_angle;
      end
      if (bus.core_step === 1'b1) begin
        if (bus.core_iter !== ITER_W'(step_cnt % N_ITER)) iter_bad++;
        step_cnt++;
      end
      if (bus.done === 1'b1) done_cnt++;
    end
  end

  task automatic clear_mon();
    clr = 1;
    @(negedge clk);
    #1;
    clr = 0;
  endtask

  logic [31:0] obs_res;
  int          obs_lat;
  bit          obs_timeout, stall_moved, stall_step;

  // Drives one operation; start re-pulsed in cycles re1/re2; clk_en low for st_len cycles from st_at.
  task automatic drive_op(input logic [31:0] a, input int re1, input int re2,
                          input int st_at, input int st_len);
    int              c;
    bit              en;
    logic [ITER_W-1:0] frz;
    obs_timeout = 0; stall_moved = 0; stall_step = 0; obs_res = '0; obs_lat = 0; frz = '0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.dataa = a; bus.clk_en = 1'b1;
    c = 1;
    forever begin
      @(posedge clk); #1;
      en = !(c >= st_at && c < st_at + st_len);
      bus.clk_en = en;
      bus.start  = (c == re1) || (c == re2);
      if (!en && c == st_at) frz = bus.core_iter;
      @(negedge clk);
      if (!en) begin
        if (bus.core_iter !== frz) stall_moved = 1;
        if (bus.core_step !== 1'b0) stall_step = 1;
      end
      if (bus.done === 1'b1) begin
        obs_lat = c;
        obs_res = bus.result;
        break;
      end
      c++;
      if (c > 200) begin
        obs_timeout = 1;
        obs_lat = c;
        break;
      end
    end
    bus.start = 1'b0;
    bus.clk_en = 1'b1;
    #1;
  endtask

  task automatic push_exp(input logic [31:0] a);
    exp_t e;
    e.res   = model_result(a);
    e.angle = model_f2x({1'b0, a[30:0]});
    sb.push_back(e);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.start = 1'b0; bus.dataa = 32'h0; bus.clk_en = 1'b1;
    clear_mon();
    repeat (2) @(negedge clk);
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    total++; if (bus.result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", bus.result); end
    total++; if (bus.core_load !== 1'b0 || bus.core_step !== 1'b0) begin
      bad++; $display("FAIL reset_core_ctl got=%b%b exp=00", bus.core_load, bus.core_step);
    end
    total++; if (bus.core_angle !== '0 || bus.core_iter !== '0) begin
      bad++; $display("FAIL reset_core_bus got=%h/%h exp=0/0", bus.core_angle, bus.core_iter);
    end
`ifdef CORDIC_SEQ_PERF_EN
    total++; if (perf_ops !== 16'd0) begin bad++; $display("FAIL reset_perf got=%0d exp=0", perf_ops); end
`endif
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] tbl[0:7];
    exp_t        e;
    tbl = '{32'h3F000000, 32'hBF000000, 32'h3F800000, 32'h3DCCCCCD,
            32'h3FFFFFFF, 32'hBF490FDB, 32'h3E800000, 32'h3F7FFFFF};
    for (int k = 0; k < 8; k++) begin
      clear_mon();
      push_exp(tbl[k]);
      drive_op(tbl[k], -1, -1, -1, 0);
      e = sb.pop_front();
      total++; if (obs_res !== e.res) begin bad++; $display("FAIL basic_result[%0d] got=%h exp=%h", k, obs_res, e.res); end
      total++; if (obs_timeout || obs_lat != N_ITER + 3) begin bad++; $display("FAIL basic_latency[%0d] got=%0d exp=%0d", k, obs_lat, N_ITER + 3); end
      total++; if (load_angle !== e.angle || load_cnt != 1) begin
        bad++; $display("FAIL basic_load[%0d] got=%h x%0d exp=%h x1", k, load_angle, load_cnt, e.angle);
      end
      total++; if (step_cnt != N_ITER || iter_bad != 0) begin
        bad++; $display("FAIL basic_steps[%0d] got=%0d bad_idx=%0d exp=%0d bad_idx=0", k, step_cnt, iter_bad, N_ITER);
      end
    end
    total++; if (model_f2x(32'h3F000000) !== 21'h080000) begin bad++; $display("FAIL half_angle_model got=%h exp=080000", model_f2x(32'h3F000000)); end
  endtask

  task automatic test_specials();
    logic [31:0] tbl[0:5];
    logic [31:0] want[0:5];
    exp_t        e;
    tbl  = '{32'h00000000, 32'h40000000, 32'h7F800000, 32'h7FC00001, 32'h00000001, 32'h35800000};
    want = '{32'h3F800000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h3F800000, 32'h00000000};
    for (int k = 0; k < 6; k++) begin
      clear_mon();
      push_exp(tbl[k]);
      drive_op(tbl[k], -1, -1, -1, 0);
      e = sb.pop_front();
      total++; if (obs_res !== want[k] || e.res !== want[k]) begin
        bad++; $display("FAIL special_result[%0d] got=%h model=%h exp=%h", k, obs_res, e.res, want[k]);
      end
      total++; if (obs_timeout || obs_lat != N_ITER + 3) begin bad++; $display("FAIL special_latency[%0d] got=%0d exp=%0d", k, obs_lat, N_ITER + 3); end
      total++; if (load_cnt != 1 || step_cnt != N_ITER) begin
        bad++; $display("FAIL special_core[%0d] got=loads %0d steps %0d exp=loads 1 steps %0d", k, load_cnt, step_cnt, N_ITER);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    clear_mon();
    push_exp(32'h3F000000);
    drive_op(32'h3F000000, 5, N_ITER + 2, -1, 0);
    e = sb.pop_front();
    total++; if (obs_res !== e.res || obs_lat != N_ITER + 3) begin
      bad++; $display("FAIL ignore_start got=%h@%0d exp=%h@%0d", obs_res, obs_lat, e.res, N_ITER + 3);
    end
    total++; if (done_cnt != 1 || load_cnt != 1) begin
      bad++; $display("FAIL ignore_start_pulses got=done %0d load %0d exp=done 1 load 1", done_cnt, load_cnt);
    end
    push_exp(32'h3F800000);
    drive_op(32'h3F800000, -1, -1, -1, 0);
    e = sb.pop_front();
    total++; if (obs_res !== e.res || obs_lat != N_ITER + 3) begin
      bad++; $display("FAIL back_to_back got=%h@%0d exp=%h@%0d", obs_res, obs_lat, e.res, N_ITER + 3);
    end
    repeat (25) @(posedge clk);
    @(negedge clk); #1;
    total++; if (done_cnt != 2 || load_cnt != 2 || step_cnt != 2 * N_ITER || iter_bad != 0) begin
      bad++; $display("FAIL back_to_back_count got=done %0d load %0d step %0d exp=done 2 load 2 step %0d",
                      done_cnt, load_cnt, step_cnt, 2 * N_ITER);
    end
  endtask

  task automatic test_stall();
    exp_t e;
    clear_mon();
    push_exp(32'h3F000000);
    drive_op(32'h3F000000, -1, -1, 6, 5);
    e = sb.pop_front();
    total++; if (obs_res !== e.res) begin bad++; $display("FAIL stall_result got=%h exp=%h", obs_res, e.res); end
    total++; if (obs_timeout || obs_lat != N_ITER + 8) begin bad++; $display("FAIL stall_latency got=%0d exp=%0d", obs_lat, N_ITER + 8); end
    total++; if (stall_moved || stall_step) begin bad++; $display("FAIL stall_frozen got=moved %0d step %0d exp=0 0", stall_moved, stall_step); end
    total++; if (step_cnt != N_ITER || iter_bad != 0) begin bad++; $display("FAIL stall_steps got=%0d exp=%0d", step_cnt, N_ITER); end
  endtask

  task automatic test_reset_abort();
    exp_t e;
    clear_mon();
    @(posedge clk); #1;
    bus.start = 1'b1; bus.dataa = 32'h3F000000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    total++; if (bus.core_step !== 1'b1 || bus.core_iter !== 5'd7) begin
      bad++; $display("FAIL abort_setup got=step %b iter %0d exp=step 1 iter 7", bus.core_step, bus.core_iter);
    end
    reset_n = 1'b0;
    #1;
    total++; if (bus.done !== 1'b0 || bus.result !== 32'h0 || bus.core_load !== 1'b0 || bus.core_step !== 1'b0 ||
                 bus.core_angle !== '0 || bus.core_iter !== '0) begin
      bad++; $display("FAIL abort_clear got=%b %h %b %b %h %h exp=all zero", bus.done, bus.result,
                      bus.core_load, bus.core_step, bus.core_angle, bus.core_iter);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk); #1;
    total++; if (done_cnt != 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt); end
`ifdef CORDIC_SEQ_PERF_EN
    total++; if (perf_ops !== 16'd0) begin bad++; $display("FAIL abort_perf got=%0d exp=0", perf_ops); end
`endif
    push_exp(32'h3DCCCCCD);
    drive_op(32'h3DCCCCCD, -1, -1, -1, 0);
    e = sb.pop_front();
    total++; if (obs_res !== e.res || obs_lat != N_ITER + 3) begin
      bad++; $display("FAIL abort_recover got=%h@%0d exp=%h@%0d", obs_res, obs_lat, e.res, N_ITER + 3);
    end
`ifdef CORDIC_SEQ_PERF_EN
    @(negedge clk);
    total++; if (perf_ops !== 16'd1) begin bad++; $display("FAIL abort_perf_count got=%0d exp=1", perf_ops); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_specials();
    test_back_to_back();
    test_stall();
    test_reset_abort();
    total++; if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d exp=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
